// File: rtl/alu_arbiter_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
package alu_arbiter_pkg;

   localparam int WIDTH_DEF = 8;
   localparam int SEL_W_DEF = 2;
   localparam int CNT_W_DEF = 8;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_EXEC = 2'd1;
   localparam state_t ST_RESP = 2'd2;

   typedef logic req_id_t;

   localparam req_id_t REQ0 = 1'b0;
   localparam req_id_t REQ1 = 1'b1;

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-input round-robin arbiter: combinational grant, registered priority pointer.
module rr_arb2
   import alu_arbiter_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic req0,
   input  logic req1,
   output logic gnt0,
   output logic gnt1
);

   req_id_t ptr;

   // The pointer only matters when both requesters contend.
   assign gnt0 = en & req0 & (~req1 | (ptr == REQ0));
   assign gnt1 = en & req1 & (~req0 | (ptr == REQ1));

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= REQ0;
      end else if (gnt0) begin
         ptr <= REQ1;
      end else if (gnt1) begin
         ptr <= REQ0;
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two valid/ready requesters,
// returning each result with a one-cycle response pulse two cycles after grant.
module alu_arbiter
   import alu_arbiter_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int SEL_W = SEL_W_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [SEL_W-1:0] req0_sel,
   output logic             req0_ready,
   output logic             resp0_valid,
   output logic [WIDTH-1:0] resp0_data,
   input  logic             req1_valid,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic [SEL_W-1:0] req1_sel,
   output logic             req1_ready,
   output logic             resp1_valid,
   output logic [WIDTH-1:0] resp1_data,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [SEL_W-1:0] alu_sel,
   input  logic [WIDTH-1:0] alu_out,
   output logic             busy,
   output logic [CNT_W-1:0] done0_cnt,
   output logic [CNT_W-1:0] done1_cnt
);

   // state   | meaning
   // IDLE    | arbitrating; ready offered to the grant winner
   // EXEC    | ALU pins stable; result captured at the end of this cycle
   // RESP    | resp_valid pulse to the winner; counter already updated

   state_t  state;
   req_id_t win;
   logic    gnt0;
   logic    gnt1;
   logic    idle;

   assign idle = (state == ST_IDLE);

   rr_arb2 u_arb (
      .clk  (clk),
      .rst  (rst),
      .en   (idle),
      .req0 (req0_valid),
      .req1 (req1_valid),
      .gnt0 (gnt0),
      .gnt1 (gnt1)
   );

   assign req0_ready  = gnt0;
   assign req1_ready  = gnt1;
   assign busy        = ~idle;
   assign resp0_valid = (state == ST_RESP) & (win == REQ0);
   assign resp1_valid = (state == ST_RESP) & (win == REQ1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         win        <= REQ0;
         alu_a      <= '0;
         alu_b      <= '0;
         alu_sel    <= '0;
         resp0_data <= '0;
         resp1_data <= '0;
         done0_cnt  <= '0;
         done1_cnt  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (gnt0 | gnt1) begin
                  alu_a   <= gnt1 ? req1_a   : req0_a;
                  alu_b   <= gnt1 ? req1_b   : req0_b;
                  alu_sel <= gnt1 ? req1_sel : req0_sel;
                  win     <= gnt1 ? REQ1 : REQ0;
                  state   <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               // Counter moves with the data so it is current during the pulse.
               if (win == REQ0) begin
                  resp0_data <= alu_out;
                  done0_cnt  <= done0_cnt + CNT_W'(1);
               end else begin
                  resp1_data <= alu_out;
                  done1_cnt  <= done1_cnt + CNT_W'(1);
               end
               state <= ST_RESP;
            end
            ST_RESP: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational 8-bit ALU (operands a, b; 2-bit op select sel; 8-bit result) between two requesters.
- Each requester submits an operation through a valid/ready handshake.
- The block arbitrates round-robin, drives the ALU from registered operands, captures the result, and returns it to the winning requester with a one-cycle response pulse.
- It sits between the control units and the single shared ALU instance; the ALU is instantiated outside this block.

Parameters:
- WIDTH, 8, operand/result width in bits.
- SEL_W, 2, ALU op-select width in bits.
- CNT_W, 8, width of per-requester completed-operation counters.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- req0_valid  input  1  requester 0 has an operation pending
- req0_a  input  WIDTH  requester 0 operand a
- req0_b  input  WIDTH  requester 0 operand b
- req0_sel  input  SEL_W  requester 0 op select
- req0_ready  output  1  requester 0 operation accepted this cycle
- resp0_valid  output  1  one-cycle pulse: resp0_data valid
- resp0_data  output  WIDTH  result for requester 0
- req1_valid, req1_a, req1_b, req1_sel, req1_ready, resp1_valid, resp1_data: same as requester 0
- alu_a  output  WIDTH  registered operand a to shared ALU
- alu_b  output  WIDTH  registered operand b to shared ALU
- alu_sel  output  SEL_W  registered op select to shared ALU
- alu_out  input  WIDTH  ALU result, combinational from alu_a/alu_b/alu_sel
- busy  output  1  high in EXEC and RESP
- done0_cnt  output  CNT_W  count of responses delivered to requester 0
- done1_cnt  output  CNT_W  count of responses delivered to requester 1

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: state=IDLE, all ready/resp_valid=0, resp data=0, alu_a/alu_b/alu_sel=0, busy=0, counters=0, priority pointer=requester 0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - req*_ready is combinational and is asserted only to the grant winner.
  - Grant: if only one valid, that one wins. If both are valid, the pointer holder wins.
  - On handshake (valid & ready) at cycle T: latch the winner's a/b/sel into alu_a/alu_b/alu_sel, latch the winner id, go to EXEC. Pointer flips to the other requester.
  - With no valid: stay in IDLE; ALU pins hold their last values.
- EXEC (cycle T+1):
  - ALU inputs are stable.
  - At the clock edge, capture alu_out into the winner's resp*_data, then go to RESP.
  - ready is 0 for both requesters.
- RESP (cycle T+2):
  - resp*_valid=1 for the winner only, for exactly one cycle.
  - The winner's done counter increments, wrapping at 2^CNT_W-1 -> 0.
  - Next state is IDLE.
  - ready is 0 in RESP.
- Throughput: one operation per 3 cycles. Fixed latency from handshake to resp_valid: 2 cycles.
- resp*_data holds its value until overwritten by that requester's next result; the other requester's data is never disturbed.
- A requester must hold valid and operands stable until ready. A valid dropped before ready is simply not served (no error).
- Both valid continuously: grants alternate 0,1,0,1… Starvation-free; maximum wait for either requester is one operation.
- After a single-requester grant the pointer still flips, so the next contention goes to the other requester.
- rst asserted in any state:
  - Next edge forces all reset values.
  - An in-flight operation is dropped; no resp pulse is produced.
  - Counters clear.
- Arithmetic: block performs none itself; result width = WIDTH, passed through unmodified.

Decomposition:
- Shared package: FSM state enum (IDLE/EXEC/RESP), default WIDTH/SEL_W constants, requester-id type.
- One natural sub-module: rr_arb2 (two-input round-robin grant with pointer, pure combinational grant plus pointer register).
- FSM, operand registers and counters stay in alu_arbiter.

Test Plan:
- Bench ALU model: sel 00=a+b, 01=a-b, 10=a&b, 11=a|b.
- Single request: req0 a=0x15 b=0x1C sel=00 at T -> req0_ready at T, alu_a=0x15/alu_b=0x1C at T+1, resp0_valid at T+2 with resp0_data=0x31, done0_cnt=1, resp1_valid stays 0.
- Contention after reset: both valid; req0 sel=10 a=0x15 b=0x1C, req1 sel=11 a=0x15 b=0x9C -> req0 granted first, resp0_data=0x14. req1 granted next handshake, resp1_data=0x9D. Ready pulses alternate.
- Continuous contention, 6 ops -> grant order 0,1,0,1,0,1; done0_cnt=3, done1_cnt=3; each resp is 2 cycles after its handshake.
- Pointer after single use: req1 alone (a=0x01 b=0x1C sel=01 -> resp1_data=0xE5), then both valid -> req0 wins.
- Reset mid-op: assert rst during EXEC -> no resp pulse, alu_* = 0, counters = 0, state IDLE. A next req0 is served normally with 2-cycle latency.
- Counter wrap: 256 ops on req1 -> done1_cnt returns to 0x00; resp1_data remains correct on the last op.
